// File: rtl/mlp_sdram_infer.sv
// Streaming 3-layer binary-activation MLP that fetches pixels, weights and biases over one Avalon-MM master
// and writes one class index per image back to memory. Optional macro MLP_SAT_EN selects saturating sums.
module mlp_sdram_infer #(
  parameter int AW        = 32,
  parameter int DW        = 16,
  parameter int N_IN      = 784,
  parameter int N_H1      = 200,
  parameter int N_H2      = 200,
  parameter int N_OUT     = 10,
  parameter int N_IMG     = 400,
  parameter int ACCW      = 24,
  parameter int IMG_BASE  = 400000,
  parameter int W1_BASE   = 0,
  parameter int W2_BASE   = 162200,
  parameter int W3_BASE   = 202400,
  parameter int RES_BASE  = 300000,
  parameter int TH1       = 1,
  parameter int TH2       = 2,
  parameter int MAX_OUTST = 8
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_start,
  output logic            o_busy,
  output logic            o_done,
  output logic [AW-1:0]   o_avm_address,
  output logic            o_avm_read,
  output logic            o_avm_write,
  output logic [DW/8-1:0] o_avm_byteenable,
  output logic [DW-1:0]   o_avm_writedata,
  input  logic            i_avm_waitrequest,
  input  logic [DW-1:0]   i_avm_readdata,
  input  logic            i_avm_readdatavalid,
  output logic [7:0]      o_class_out,
  output logic            o_class_valid
);

  localparam int NM1  = (N_IN > N_H1) ? N_IN : N_H1;
  localparam int NM2  = (N_H2 > N_OUT) ? N_H2 : N_OUT;
  localparam int NMAX = (NM1 > NM2) ? NM1 : NM2;
  localparam int CW   = $clog2(NMAX + 1);
  localparam int XW   = $clog2(N_IN);
  localparam int H1W  = $clog2(N_H1);
  localparam int H2W  = $clog2(N_H2);
  localparam int NBW  = $clog2(NMAX);
  localparam int IMW  = $clog2(N_IMG + 1);
  localparam int T_L1 = N_H1 * N_IN + N_H1;
  localparam int T_L2 = N_H2 * N_H1 + N_H2;
  localparam int T_L3 = N_OUT * N_H2 + N_OUT;
  localparam logic signed [ACCW-1:0] ACC_MIN = {1'b1, {(ACCW-1){1'b0}}};
`ifdef MLP_SAT_EN
  localparam logic signed [ACCW-1:0] ACC_MAX = {1'b0, {(ACCW-1){1'b1}}};
`endif

  typedef enum logic [2:0] {S_IDLE, S_IMG, S_L1, S_L2, S_L3, S_WR, S_DONE} state_t;

  function automatic logic signed [ACCW-1:0] f_add(input logic signed [ACCW-1:0] a,
                                                   input logic signed [ACCW-1:0] b);
`ifdef MLP_SAT_EN
    logic signed [ACCW:0] s;
    s = {a[ACCW-1], a} + {b[ACCW-1], b};
    if (s[ACCW] != s[ACCW-1]) return s[ACCW] ? ACC_MIN : ACC_MAX;
    return s[ACCW-1:0];
`else
    return a + b;
`endif
  endfunction

  state_t                  r_state, w_state_next;
  logic [IMW-1:0]          r_img;
  logic [AW-1:0]           r_img_base, r_issue;
  logic [3:0]              r_outst;
  logic [CW-1:0]           r_idx, r_node;
  logic                    r_bias_ph;
  logic signed [ACCW-1:0]  r_acc, r_max;
  logic [7:0]              r_cls, r_class_out;
  logic                    r_class_valid;
  logic [N_IN-1:0]         r_x;
  logic [N_H1-1:0]         r_h1;
  logic [N_H2-1:0]         r_h2;
  logic signed [ACCW-1:0]  r_node_buf [NMAX];

  logic                    w_rd_state, w_accept_rd, w_rsp, w_last_rsp, w_wr_acc, w_in_bit, w_better, w_node_we;
  logic [AW-1:0]           w_total, w_base;
  logic [CW-1:0]           w_m_last, w_n_last;
  logic signed [ACCW-1:0]  w_th, w_dext, w_acc_sum, w_bsum;

  // Per-state read window geometry and the input bit that gates the current weight.
  always_comb begin
    w_total  = AW'(N_IN);
    w_base   = r_img_base;
    w_m_last = CW'(N_IN - 1);
    w_n_last = '0;
    w_in_bit = 1'b0;
    w_th     = '0;
    case (r_state)
      S_L1: begin
        w_total = AW'(T_L1); w_base = AW'(W1_BASE); w_m_last = CW'(N_IN - 1);
        w_n_last = CW'(N_H1 - 1); w_in_bit = r_x[r_idx[XW-1:0]]; w_th = ACCW'(TH1);
      end
      S_L2: begin
        w_total = AW'(T_L2); w_base = AW'(W2_BASE); w_m_last = CW'(N_H1 - 1);
        w_n_last = CW'(N_H2 - 1); w_in_bit = r_h1[r_idx[H1W-1:0]]; w_th = ACCW'(TH2);
      end
      S_L3: begin
        w_total = AW'(T_L3); w_base = AW'(W3_BASE); w_m_last = CW'(N_H2 - 1);
        w_n_last = CW'(N_OUT - 1); w_in_bit = r_h2[r_idx[H2W-1:0]];
      end
      default: ;
    endcase
  end

  assign w_rd_state  = (r_state == S_IMG) || (r_state == S_L1) || (r_state == S_L2) || (r_state == S_L3);
  assign w_accept_rd = o_avm_read & ~i_avm_waitrequest;
  // Stray readdatavalid with nothing in flight is dropped here.
  assign w_rsp       = i_avm_readdatavalid & (r_outst != 4'd0) & w_rd_state;
  assign w_last_rsp  = w_rsp & ((r_state == S_IMG) ? (r_idx == w_m_last) : (r_bias_ph & (r_node == w_n_last)));
  assign w_wr_acc    = (r_state == S_WR) & ~i_avm_waitrequest;
  assign w_dext      = ACCW'($signed(i_avm_readdata));
  assign w_acc_sum   = f_add(r_acc, w_in_bit ? w_dext : '0);
  assign w_bsum      = f_add(r_node_buf[r_node[NBW-1:0]], w_dext);
  assign w_better    = w_bsum > r_max;
  assign w_node_we   = w_rsp & (r_state != S_IMG) & ~r_bias_ph & (r_idx == w_m_last);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_next = S_IMG;
      S_IMG:   if (w_last_rsp) w_state_next = S_L1;
      S_L1:    if (w_last_rsp) w_state_next = S_L2;
      S_L2:    if (w_last_rsp) w_state_next = S_L3;
      S_L3:    if (w_last_rsp) w_state_next = S_WR;
      S_WR:    if (w_wr_acc) w_state_next = (r_img == IMW'(N_IMG - 1)) ? S_DONE : S_IMG;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy          = (r_state != S_IDLE);
    o_done          = (r_state == S_DONE);
    o_avm_read      = w_rd_state && (r_issue < w_total) && (r_outst < 4'(MAX_OUTST));
    o_avm_write     = (r_state == S_WR);
    o_avm_address   = '0;
    o_avm_writedata = '0;
    if (w_rd_state) o_avm_address = w_base + r_issue;
    if (r_state == S_WR) begin
      o_avm_address   = AW'(RES_BASE) + AW'(r_img);
      o_avm_writedata = DW'(r_cls);
    end
  end

  assign o_avm_byteenable = '1;
  assign o_class_out      = r_class_out;
  assign o_class_valid    = r_class_valid;

  always_ff @(posedge i_clk) begin
    if (w_node_we) r_node_buf[r_node[NBW-1:0]] <= w_acc_sum;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_img <= '0; r_img_base <= '0; r_issue <= '0; r_outst <= '0;
      r_idx <= '0; r_node <= '0; r_bias_ph <= 1'b0; r_acc <= '0; r_max <= '0;
      r_cls <= '0; r_class_out <= '0; r_class_valid <= 1'b0;
      r_x <= '0; r_h1 <= '0; r_h2 <= '0;
    end else begin
      if (w_accept_rd && !w_rsp)      r_outst <= r_outst + 4'd1;
      else if (!w_accept_rd && w_rsp) r_outst <= r_outst - 4'd1;
      if (w_accept_rd) r_issue <= r_issue + AW'(1);
      if (w_rsp) begin
        if (r_state == S_IMG) begin
          r_x[r_idx[XW-1:0]] <= |i_avm_readdata;
          r_idx <= r_idx + CW'(1);
        end else if (!r_bias_ph) begin
          if (r_idx == w_m_last) begin
            r_acc <= '0;
            r_idx <= '0;
            r_node <= (r_node == w_n_last) ? '0 : r_node + CW'(1);
            if (r_node == w_n_last) r_bias_ph <= 1'b1;
          end else begin
            r_acc <= w_acc_sum;
            r_idx <= r_idx + CW'(1);
          end
        end else begin
          r_node <= r_node + CW'(1);
          case (r_state)
            S_L1:    r_h1[r_node[H1W-1:0]] <= (w_bsum >= w_th);
            S_L2:    r_h2[r_node[H2W-1:0]] <= (w_bsum >= w_th);
            default: if (w_better) begin r_max <= w_bsum; r_cls <= 8'(r_node); end
          endcase
        end
      end
      if (r_state == S_IDLE && i_start) begin
        r_img <= '0;
        r_img_base <= AW'(IMG_BASE);
      end
      r_class_valid <= w_wr_acc;
      if (w_wr_acc) begin
        r_class_out <= r_cls;
        r_img <= r_img + IMW'(1);
        r_img_base <= r_img_base + AW'(N_IN);
      end
      // Counters restart on every state change; the final response's own updates above still land.
      if (w_state_next != r_state) begin
        r_issue <= '0; r_idx <= '0; r_node <= '0; r_bias_ph <= 1'b0; r_acc <= '0;
      end
      if (w_state_next == S_L3 && r_state != S_L3) begin
        r_max <= ACC_MIN;
        r_cls <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mlp_sdram_infer.sv
// Scoreboard bench for mlp_sdram_infer: a bus model serves a small word memory, expected classes are queued
// per run and a monitor checks each class_valid pulse and the written result word.
module tb_mlp_sdram_infer;
  localparam int AW = 32, DW = 16, N_IN = 4, N_H1 = 3, N_H2 = 3, N_OUT = 2, N_IMG = 2, ACCW = 16;
  localparam int W1B = 0, W2B = 100, W3B = 200, IMGB = 300, RESB = 400, MAXO = 3;

  logic          clk = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic          busy, done, avm_read, avm_write, class_valid;
  logic [AW-1:0] addr;
  logic [1:0]    be;
  logic [DW-1:0] wdata, rdata;
  logic          waitreq, rdv;
  logic [7:0]    class_out;

  always #5 clk = ~clk;

  mlp_sdram_infer #(
    .AW(AW), .DW(DW), .N_IN(N_IN), .N_H1(N_H1), .N_H2(N_H2), .N_OUT(N_OUT), .N_IMG(N_IMG), .ACCW(ACCW),
    .IMG_BASE(IMGB), .W1_BASE(W1B), .W2_BASE(W2B), .W3_BASE(W3B), .RES_BASE(RESB),
    .TH1(1), .TH2(2), .MAX_OUTST(MAXO)
  ) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_start(start), .o_busy(busy), .o_done(done),
    .o_avm_address(addr), .o_avm_read(avm_read), .o_avm_write(avm_write), .o_avm_byteenable(be),
    .o_avm_writedata(wdata), .i_avm_waitrequest(waitreq), .i_avm_readdata(rdata),
    .i_avm_readdatavalid(rdv), .o_class_out(class_out), .o_class_valid(class_valid)
  );

  typedef struct { logic [15:0] d; int due; } rsp_t;
  typedef struct { int img; int cls; } exp_t;
  logic [15:0] mem [0:511];
  rsp_t rq[$];
  exp_t sb[$];
  int total = 0, bad = 0, cyc = 0, mode = 0, outst_m = 0, max_outst = 0, done_cnt = 0, stray = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Bus model: decides waitrequest/readdatavalid for the coming edge, responses strictly in order.
  initial begin
    rsp_t r;
    waitreq = 1'b0; rdv = 1'b0; rdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        rq.delete(); outst_m = 0; rdv = 1'b0; waitreq = 1'b0;
      end else begin
        rdv = 1'b0; rdata = 16'hDEAD;
        if (rq.size() > 0 && rq[0].due <= cyc) begin
          rdv = 1'b1; rdata = rq[0].d; void'(rq.pop_front()); outst_m--;
        end else if (stray > 0) begin
          rdv = 1'b1; stray--;
        end
        waitreq = (mode == 1) && ($urandom_range(0, 1) == 1);
        if (avm_read && !waitreq) begin
          r.d = mem[addr[8:0]];
          r.due = cyc + ((mode == 1) ? int'($urandom_range(1, 6)) : 1);
          rq.push_back(r);
          outst_m++;
          if (outst_m > max_outst) max_outst = outst_m;
        end
        if (avm_write && !waitreq) mem[addr[8:0]] = wdata;
      end
    end
  end

  // Monitor: one line per classified image, compared against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && done) done_cnt++;
      if (reset_n && class_valid) begin
        if (sb.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          e = sb.pop_front();
          $display("result img=%0d class=%0d expected=%0d", e.img, class_out, e.cls);
          chk("class_out", int'(class_out), e.cls);
          chk("res_word", int'(mem[RESB + e.img]), e.cls);
          mem[RESB + e.img] = 16'hFFFF;
        end
      end
    end
  end

  task automatic fill(input int base, input int n, input int val);
    for (int i = 0; i < n; i++) mem[base + i] = 16'(val);
  endtask

  task automatic set_img(input int img, input int p0, input int p1, input int p2, input int p3);
    mem[IMGB + img*4 + 0] = 16'(p0); mem[IMGB + img*4 + 1] = 16'(p1);
    mem[IMGB + img*4 + 2] = 16'(p2); mem[IMGB + img*4 + 3] = 16'(p3);
  endtask

  task automatic cfg_a();
    fill(W1B, 12, 1); fill(W1B + 12, 3, 0);
    fill(W2B, 9, 1);  fill(W2B + 9, 3, -1);
    fill(W3B, 3, 1);  fill(W3B + 3, 3, 2); fill(W3B + 6, 2, 0);
    set_img(0, 1, 0, 2, 0); set_img(1, 0, 0, 0, 0);
    fill(RESB, 2, -1);
  endtask

  task automatic expect_run(input int c0, input int c1);
    exp_t e;
    e.img = 0; e.cls = c0; sb.push_back(e);
    e.img = 1; e.cls = c1; sb.push_back(e);
  endtask

  task automatic wait_done(input string name, input int limit);
    int got = 0;
    for (int i = 0; i < limit && got == 0; i++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    chk(name, got, 1);
  endtask

  task automatic run(input string name, input int limit);
    int d0 = done_cnt;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({name, "_busy"}, int'(busy), 1);
    wait_done({name, "_done"}, limit);
    repeat (3) @(negedge clk);
    chk({name, "_done_cnt"}, done_cnt - d0, 1);
    chk({name, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin
    int found, d0;
    for (int i = 0; i < 512; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_read", int'(avm_read), 0);
    chk("rst_write", int'(avm_write), 0);
    chk("rst_be", int'(be), 3);
    chk("rst_addr", int'(addr), 0);
    chk("rst_cvalid", int'(class_valid), 0);
    chk("rst_class", int'(class_out), 0);
    reset_n = 1'b1;

    cfg_a(); expect_run(1, 0); run("basic", 2000);

    stray = 2;
    repeat (6) @(negedge clk);
    chk("stray_busy", int'(busy), 0);
    chk("stray_read", int'(avm_read), 0);

    fill(W3B, 3, -7); fill(W3B + 3, 3, -5); expect_run(1, 0); run("negmax", 2000);
    fill(W3B, 6, 3); expect_run(0, 0); run("tie", 2000);

    mode = 1; max_outst = 0;
    cfg_a(); expect_run(1, 0); run("random", 8000);
    chk("max_outst_le3", int'(max_outst <= MAXO), 1);
    mode = 0;

    fill(W1B, 4, 16'h7000); fill(W1B + 4, 11, 0);
    fill(W2B, 12, 0); mem[W2B] = 16'd2; mem[W2B + 3] = 16'd2; mem[W2B + 6] = 16'd2;
    fill(W3B, 3, 0); fill(W3B + 3, 3, 1); fill(W3B + 6, 2, 0);
    set_img(0, 5, 1, -1, 7); set_img(1, 0, 0, 0, 0);
`ifdef MLP_SAT_EN
    expect_run(1, 0);
`else
    expect_run(0, 0);
`endif
    run("sat", 2000);

    cfg_a(); expect_run(1, 0);
    d0 = done_cnt;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    found = 0;
    for (int i = 0; i < 2000 && found == 0; i++) begin
      @(negedge clk);
      if (avm_read && addr >= W2B && addr < W3B) found = 1;
    end
    chk("reach_l2", found, 1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("abort_read", int'(avm_read), 0);
    chk("abort_busy", int'(busy), 0);
    reset_n = 1'b1;
    sb.delete();
    repeat (5) @(negedge clk);
    chk("abort_idle", int'(busy), 0);
    chk("abort_no_done", done_cnt - d0, 0);
    expect_run(1, 0); run("rerun", 2000);

    cfg_a(); expect_run(1, 0); expect_run(1, 0);
    d0 = done_cnt;
    @(negedge clk); start = 1'b1;
    wait_done("held_done1", 2000);
    @(negedge clk);
    chk("held_idle_gap", int'(busy), 0);
    @(negedge clk);
    chk("held_restart", int'(busy), 1);
    start = 1'b0;
    wait_done("held_done2", 2000);
    repeat (20) @(negedge clk);
    chk("held_final_idle", int'(busy), 0);
    chk("held_done_cnt", done_cnt - d0, 2);
    chk("held_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
